// File: rtl/regmode_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regmode_cfg_ctrl
// Purpose  : Configuration sequencer for a bank of register-mode cells.
//            Accepts write-data / write-mode / read requests on a valid/ready
//            channel, quiesces the target cell's clk_en for SETTLE cycles,
//            performs the config action in a single EXEC cycle and returns a
//            response on a valid/ready channel.
// Ports    : CLK, RESETN (sync, active-low)
//            cfg_valid/cfg_ready/cfg_op/cfg_addr/cfg_wdata : request channel
//            rsp_valid/rsp_ready/rsp_data/rsp_err          : response channel
//            reg_O       : packed cell outputs (cell i at [i*WIDTH +: WIDTH])
//            mode        : packed 2-bit per-cell mode
//            config_we   : one-hot cell config write strobe
//            config_data : broadcast config write data
//            clk_en      : per-cell clock enable
// Options  : REGMODE_CFG_PARITY_EN adds cfg_parity (even parity over
//            {cfg_op, cfg_addr, cfg_wdata}); a mismatch is a request error.
// Revision : 1.0 - initial release
// ============================================================================
module regmode_cfg_ctrl #(
    parameter int NUM_REGS = 4,
    parameter int WIDTH    = 4,
    parameter int ADDR_W   = 2,
    parameter int SETTLE   = 2
) (
    input  logic                      CLK,
    input  logic                      RESETN,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [1:0]                cfg_op,
    input  logic [ADDR_W-1:0]         cfg_addr,
    input  logic [WIDTH-1:0]          cfg_wdata,
`ifdef REGMODE_CFG_PARITY_EN
    input  logic                      cfg_parity,
`endif
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      rsp_err,
    input  logic [NUM_REGS*WIDTH-1:0] reg_O,
    output logic [2*NUM_REGS-1:0]     mode,
    output logic [NUM_REGS-1:0]       config_we,
    output logic [WIDTH-1:0]          config_data,
    output logic [NUM_REGS-1:0]       clk_en
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_QUIESCE = 2'd1,
        S_EXEC    = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);
    localparam logic [1:0] OP_WDATA = 2'b00;
    localparam logic [1:0] OP_WMODE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [WIDTH-1:0]        wdata_q, wdata_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [2*NUM_REGS-1:0]   mode_q, mode_d;
    logic [WIDTH-1:0]        cfgdata_q, cfgdata_d;
    logic [WIDTH-1:0]        rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    req_err;
    logic [WIDTH-1:0]        sel_data;

    // Request error classification, evaluated on the live request inputs.
    always_comb begin
        req_err = (32'(cfg_addr) >= 32'(NUM_REGS)) ||
                  (cfg_op == OP_RSVD) ||
                  ((cfg_op == OP_WMODE) && (cfg_wdata[1:0] == 2'b11));
`ifdef REGMODE_CFG_PARITY_EN
        if (cfg_parity != ^{cfg_op, cfg_addr, cfg_wdata}) begin
            req_err = 1'b1;
        end
`endif
    end

    // Readback mux over the target cell's output slice.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                sel_data = reg_O[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        cfgdata_d = cfgdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    op_d    = cfg_op;
                    addr_d  = cfg_addr;
                    wdata_d = cfg_wdata;
                    cnt_d   = SETTLE_C;
                    rdata_d = '0;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (SETTLE_C != 4'd0) begin
                        state_d = S_QUIESCE;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_QUIESCE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_WDATA: cfgdata_d = wdata_q;
                    OP_WMODE: begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (addr_q == ADDR_W'(i)) begin
                                mode_d[2*i +: 2] = wdata_q[1:0];
                            end
                        end
                    end
                    OP_READ:  rdata_d = sel_data;
                    default:  ;
                endcase
                state_d = S_RESP;
            end
            S_RESP: begin
                // Only the response handshake is honoured here; a pending
                // cfg_valid waits until IDLE raises cfg_ready.
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            mode_q    <= {NUM_REGS{2'b10}};
            cfgdata_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            cfgdata_q <= cfgdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Outputs decoded from registered state; the target cell stays gated
    // through EXEC so its config action lands on a frozen cell.
    always_comb begin
        cfg_ready   = (state_q == S_IDLE);
        rsp_valid   = (state_q == S_RESP);
        rsp_data    = rdata_q;
        rsp_err     = err_q;
        mode        = mode_q;
        config_data = ((state_q == S_EXEC) && (op_q == OP_WDATA)) ? wdata_q : cfgdata_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            clk_en[i]    = !(((state_q == S_QUIESCE) || (state_q == S_EXEC)) &&
                             (addr_q == ADDR_W'(i)));
            config_we[i] = (state_q == S_EXEC) && (op_q == OP_WDATA) &&
                           (addr_q == ADDR_W'(i));
        end
    end

endmodule
`default_nettype wire
